// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode / operand-fetch stage in front of the ALU.
//
// Accepts RV32I R-type and I-type ALU instructions, reads the 32x32 register
// file and registers an operand bundle {in0, in1, selector, rd} for the ALU.
// ALU results return on the writeback port. A busy-bit scoreboard stalls any
// instruction whose source register still has a result outstanding.
//
// Optional feature macro: ALU_ISSUE_WB_BYPASS_EN
//   defined   - wb_data is forwarded into the operand read, so a source that
//               is written back this cycle does not stall.
//   undefined - a source that is busy at the start of the cycle stalls even
//               if it is written this cycle; the dependent instruction
//               transfers one cycle later and reads the register file.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both high. Valid never waits for ready. Once out_valid is high,
// the bundle stays stable until the edge where out_ready is also high.
// instr_ready = (!out_valid | out_ready) & !hazard; illegal opcodes ignore the
// hazard term, are consumed, are never issued, and pulse `illegal` for one
// cycle.

module alu_issue_stage #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       in0,
    output logic [31:0]       in1,
    output logic [9:0]        selector,
    output logic [ADDR_W-1:0] rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [31:0]       wb_data,
    output logic              illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         in0_q, in0_d;
    logic [31:0]         in1_q, in1_d;
    logic [9:0]          selector_q, selector_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                illegal_q, illegal_d;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [ADDR_W-1:0] dec_rd;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [6:0]        funct7;
    logic [31:0]       imm_i;

    assign opcode = instr[6:0];
    assign dec_rd = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};

    logic is_r, is_i, is_legal;
    logic use_rs1, use_rs2;

    assign is_r     = (opcode == OPC_R);
    assign is_i     = (opcode == OPC_I);
    assign is_legal = is_r | is_i;
    assign use_rs1  = is_legal;
    assign use_rs2  = is_r;

    // A writeback to x0 is a no-op everywhere.
    logic wb_write;
    assign wb_write = wb_en && (wb_rd != '0);

    // ------------------------------------------------------------------
    // Operand read and hazard detection
    // ------------------------------------------------------------------
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic        hazard;
    logic        fire;
    logic        issue;

    // Read both sources; x0 is forced to zero, optional writeback forwarding.
    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_write && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_write && (wb_rd == rs2)) rs2_val = wb_data;
`endif
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    // A source is pending while its busy bit is set; with forwarding, a
    // same-cycle writeback to it resolves the dependency immediately.
    always_comb begin
        rs1_busy = busy_q[rs1];
        rs2_busy = busy_q[rs2];
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_write && (wb_rd == rs1)) rs1_busy = 1'b0;
        if (wb_write && (wb_rd == rs2)) rs2_busy = 1'b0;
`endif
        hazard = is_legal && ((use_rs1 && rs1_busy) || (use_rs2 && rs2_busy));
    end

    assign instr_ready = (!out_valid_q || out_ready) && !hazard;
    assign fire        = instr_valid && instr_ready;
    assign issue       = fire && is_legal;

    // ------------------------------------------------------------------
    // Output bundle, illegal pulse
    // ------------------------------------------------------------------
    // Load a new bundle on issue, drop valid when consumed, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        selector_d  = selector_q;
        rd_d        = rd_q;
        illegal_d   = fire && !is_legal;

        if (issue) begin
            out_valid_d = 1'b1;
            in0_d       = rs1_val;
            rd_d        = dec_rd;
            if (is_r) begin
                in1_d      = rs2_val;
                selector_d = {funct7, funct3};
            end else begin
                in1_d = imm_i;
                // Only the shift-immediates carry meaningful funct7 bits.
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    selector_d = {funct7, funct3};
                end else begin
                    selector_d = {7'b0, funct3};
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and register file
    // ------------------------------------------------------------------
    // Writeback clears first, issue sets last so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_write) busy_d[wb_rd] = 1'b0;
        if (issue && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Writeback always lands in the register file, regardless of busy bits.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_write) regs_d[wb_rd] = wb_data;
        regs_d[0] = '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Bundle, pulse and scoreboard flops; reset discards any held bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            selector_q  <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            selector_q  <= selector_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
        end
    end

    // Register file storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign in0       = in0_q;
    assign in1       = in1_q;
    assign selector  = selector_q;
    assign rd        = rd_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage.
// Expected bundles are pushed into exp_q when an instruction is driven; a
// monitor pops and compares whenever the ALU side consumes a bundle.

module tb_alu_issue_stage;

    localparam int ADDR_W = 5;
    localparam int BW     = 32 + 32 + 10 + ADDR_W;

`ifdef ALU_ISSUE_WB_BYPASS_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 1;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic [31:0]       instr = '0;
    logic              instr_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       in0;
    logic [31:0]       in1;
    logic [9:0]        selector;
    logic [ADDR_W-1:0] rd;
    logic              wb_en = 1'b0;
    logic [ADDR_W-1:0] wb_rd = '0;
    logic [31:0]       wb_data = '0;
    logic              illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.NUM_REGS(32), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .in0         (in0),
        .in1         (in1),
        .selector    (selector),
        .rd          (rd),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and check helpers
    // ------------------------------------------------------------------
    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int ill_seen = 0;
    int exp_ill  = 0;

    function automatic logic [BW-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                           input logic [9:0] s, input logic [ADDR_W-1:0] r);
        return {a, b, s, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_bundle(input string name, input logic [BW-1:0] exp);
        logic [BW-1:0] act;
        act = pack(in0, in1, selector, rd);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got in0=%h in1=%h sel=%h rd=%0d expected in0=%h in1=%h sel=%h rd=%0d",
                      name, in0, in1, selector, rd,
                      exp[BW-1 -: 32], exp[BW-33 -: 32], exp[ADDR_W +: 10], exp[ADDR_W-1:0]);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare every consumed bundle against the expected queue
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_bundle: got in0=%h in1=%h sel=%h rd=%0d expected none",
                         in0, in1, selector, rd);
            end else begin
                chk_bundle("bundle", exp_q.pop_front());
            end
        end
        if (rst_n && illegal) ill_seen++;
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] w, output int waited);
        instr       = w;
        instr_valid = 1'b1;
        waited      = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got instr_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wb(input logic [ADDR_W-1:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    // Drive a dependent instruction, confirm it stalls, then write back its
    // source and measure the cycles from writeback to transfer.
    task automatic hazard_case(input string name, input logic [31:0] w, input int stall_cyc,
                               input logic [ADDR_W-1:0] r, input logic [31:0] d);
        int lat;
        instr       = w;
        instr_valid = 1'b1;
        repeat (stall_cyc) begin
            @(negedge clk);
            chk({name, "_stall"}, instr_ready, 0);
        end
        @(posedge clk);
        #1;
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        lat     = 0;
        @(negedge clk);
        while (!instr_ready && lat < 5) begin
            @(posedge clk);
            #1;
            wb_en = 1'b0;
            lat++;
            @(negedge clk);
        end
        chk({name, "_wb_to_transfer"}, lat, EXP_LAT);
        @(posedge clk);
        #1;
        wb_en       = 1'b0;
        instr_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int waited;

        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in0", in0, 0);
        chk("rst_in1", in1, 0);
        chk("rst_selector", selector, 0);
        chk("rst_rd", rd, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instr_ready", instr_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // x1 = x2 = 5, then add x3,x1,x2.
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd5);
        exp_q.push_back(pack(32'd5, 32'd5, 10'h000, 5'd3));
        send(32'h002081B3, waited);
        chk("add_latency_out_valid", out_valid, 1);
        wb(5'd3, 32'd7);

        // Backpressure: addi x4,x0,-1 held while srai x5,x1,1 waits.
        out_ready = 1'b0;
        exp_q.push_back(pack(32'd0, 32'hFFFF_FFFF, 10'h000, 5'd4));
        send(32'hFFF00213, waited);
        exp_q.push_back(pack(32'd5, 32'h0000_0401, 10'h105, 5'd5));
        instr       = 32'h4010D293;
        instr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_instr_ready", instr_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk_bundle("bp_hold", pack(32'd0, 32'hFFFF_FFFF, 10'h000, 5'd4));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", instr_ready, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;

        // andi x8,x1,-16: funct7 bits of the immediate must not reach selector.
        exp_q.push_back(pack(32'd5, 32'hFFFF_FFF0, 10'h007, 5'd8));
        send(32'hFF00F413, waited);

        // RAW hazard: add x3, then sub x6,x3,x1 waits for wb x3=10.
        exp_q.push_back(pack(32'd5, 32'd5, 10'h000, 5'd3));
        send(32'h002081B3, waited);
        exp_q.push_back(pack(32'd10, 32'd5, 10'h100, 5'd6));
        hazard_case("sub_raw", 32'h40118333, 2, 5'd3, 32'd10);

        // Illegal opcode whose rs1 field names busy x6: no stall, no issue.
        exp_ill++;
        send(32'h0003007F, waited);
        chk("illegal_no_stall", waited, 0);
        @(negedge clk);
        chk("illegal_pulse", illegal, 1);
        chk("illegal_no_issue", out_valid, 0);
        @(negedge clk);
        chk("illegal_one_cycle", illegal, 0);

        // Writeback to x0 is ignored: add x7,x0,x0 reads zero.
        wb(5'd0, 32'h0000_1234);
        exp_q.push_back(pack(32'd0, 32'd0, 10'h000, 5'd7));
        send(32'h000003B3, waited);

        // Same-cycle set and clear on x9: set wins, so add x10,x9,x0 stalls.
        wb_en   = 1'b1;
        wb_rd   = 5'd9;
        wb_data = 32'h55;
        exp_q.push_back(pack(32'd0, 32'd1, 10'h000, 5'd9));
        send(32'h00100493, waited);
        wb_en = 1'b0;
        exp_q.push_back(pack(32'h66, 32'd0, 10'h000, 5'd10));
        hazard_case("set_wins", 32'h00048533, 2, 5'd9, 32'h66);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset with a held bundle and x3 busy.
        out_ready = 1'b0;
        send(32'h002081B3, waited);
        @(negedge clk);
        chk("pre_reset_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in0", in0, 0);
        chk("async_rst_rd", rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // add x11,x3,x1: x3 no longer busy, x1 cleared to 0.
        exp_q.push_back(pack(32'd0, 32'd0, 10'h000, 5'd11));
        send(32'h001185B3, waited);
        chk("post_reset_no_stall", waited, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("illegal_count", ill_seen, exp_ill);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU (`in0`/`in1`/`selector`/`zero`/`out0`).
- Accepts 32-bit RV32I ALU instructions (R-type and I-type) over a valid/ready handshake and reads a 32x32 register file.
- Drives a registered operand bundle (`in0`, `in1`, 10-bit `selector` = {funct7, funct3}) to the ALU.
- Takes ALU results back on a writeback port and tracks pending destinations with a busy-bit scoreboard.

Parameters:
- `NUM_REGS`, 32, number of architectural registers; x0 is hardwired to zero.
- `ADDR_W`, 5, register index width; must satisfy 2**`ADDR_W` == `NUM_REGS`.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `instr_valid`  input  1  upstream instruction valid.
- `instr`  input  32  RV32I instruction word.
- `instr_ready`  output  1  stage accepts `instr` this cycle.
- `out_valid`  output  1  operand bundle valid to ALU.
- `out_ready`  input  1  downstream consumes the bundle.
- `in0`  output  32  operand A (rs1 value).
- `in1`  output  32  operand B (rs2 value or sign-extended immediate).
- `selector`  output  10  {funct7, funct3} for ALU.
- `rd`  output  ADDR_W  destination register travelling with the bundle.
- `wb_en`  input  1  writeback strobe.
- `wb_rd`  input  ADDR_W  writeback register.
- `wb_data`  input  32  writeback value (ALU `out0`).
- `illegal`  output  1  one-cycle pulse when an unsupported opcode is accepted and dropped.

Behaviour:
- Reset (async, `rst_n`=0):
  - `out_valid`=0; `in0`/`in1`/`selector`/`rd`=0; `illegal`=0.
  - All registers and all busy bits cleared.
  - Mid-operation reset discards any held bundle; nothing is replayed.
- Decode:
  - Opcode 0110011 (R): `in1`=R[rs2]; `selector`={instr[31:25], instr[14:12]}; uses rs1 and rs2.
  - Opcode 0010011 (I): `in1`=sign-extended instr[31:20]; uses rs1 only.
    - funct3 001/101: `selector`={instr[31:25], funct3}.
    - Otherwise: `selector`={7'b0, funct3}.
  - Any other opcode: illegal.
- Register read: x0 always reads 0.
- Hazard: stall when any used source has its busy bit set and is not cleared by a writeback this cycle (see WB_BYPASS_EN).
- Handshake:
  - `instr_ready` = (!`out_valid` | `out_ready`) & !hazard.
  - Transfer occurs when `instr_valid` & `instr_ready`.
  - Bundle registered on the transfer edge; latency 1 cycle from transfer to `out_valid`.
  - `out_valid` stays high with stable `in0`/`in1`/`selector`/`rd` until `out_ready`.
  - Back-to-back transfers allowed: full throughput when there is no hazard.
  - If `out_ready` is high with no new transfer, `out_valid` falls next cycle.
- Illegal instruction: accepted (subject to `instr_ready`, hazard ignored), not issued, `illegal` pulses for 1 cycle.
- Scoreboard:
  - Transfer of a legal instruction with `rd`≠0 sets busy[`rd`].
  - `wb_en` with `wb_rd`≠0 writes R[`wb_rd`] and clears busy[`wb_rd`].
  - Same-cycle set and clear on the same index: set wins, and the register file is still written.
  - Writeback to x0 is ignored.
- Busy bits never block writeback.

Optional Feature:
- Macro: `ALU_ISSUE_WB_BYPASS_EN`.
- Defined: `wb_data` is forwarded combinationally into the operand read, and a source being written this cycle is not a hazard. A dependent instruction transfers in the same cycle as the writeback.
- Undefined: a source busy at the start of the cycle stalls even if written this cycle. The instruction transfers on the following cycle and reads the register file. Adds one bubble per dependency.

Test Plan:
- Reset, then write x1=5 and x2=5 via wb; `instr` add x3,x1,x2 (0x002081B3) -> next cycle `out_valid`=1, `in0`=5, `in1`=5, `selector`=10'h000, `rd`=3, busy[3]=1.
- Hold `out_ready`=0 for 3 cycles with a second instruction valid -> `instr_ready`=0, bundle unchanged; `out_ready`=1 -> second bundle appears next cycle.
- addi x4,x0,-1 (0xFFF00213) -> `in0`=0, `in1`=0xFFFFFFFF, `selector`=10'h000; srai x5,x1,1 (0x4010D293) -> `selector`=10'h105, `in1`=0x401.
- add x3 issued, then sub x6,x3,x1 -> stalls while busy[3]; wb x3=10:
  - With macro: transfers that cycle with `in0`=10.
  - Without macro: transfers one cycle later with `in0`=10.
- `instr`=0x0000007F -> `illegal` pulses 1 cycle, `out_valid` stays 0; wb to x0 with data 0x1234, then read x0 -> 0.
- Assert `rst_n`=0 asynchronously while `out_valid`=1 and busy[3]=1 -> `out_valid`, busy bits, and registers all 0 immediately.
